// File: rtl/stream_pool2d_if.sv
// Stream bundle for the pooling stage: pixel input and pooled-pixel output,
// each with a valid/ready handshake. The pooling block is the slave side.
interface stream_pool2d_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/stream_pool2d.sv
// Streaming non-overlapping KxK max/average pooling over a raster pixel
// stream. Horizontal partials live in one register per channel; vertical
// partials live in a single row of OUT_COLS entries.
module stream_pool2d #(
  parameter int IN_CH  = 4,
  parameter int DATA_W = 8,
  parameter int KERNEL = 2,
  parameter int ROWS   = 28,
  parameter int COLS   = 28,
  parameter int MODE   = 0
) (
  input  logic           clk,
  input  logic           rst,
  stream_pool2d_if.slave bus,
  output logic           frame_busy
);

  localparam int OUT_ROWS = ROWS / KERNEL;
  localparam int OUT_COLS = COLS / KERNEL;
  localparam int LK       = $clog2(KERNEL);
  localparam int ACC_W    = DATA_W + 2 * LK;
  localparam int DW       = IN_CH * DATA_W;
  localparam int RW       = $clog2(ROWS + 1);
  localparam int CW       = $clog2(COLS + 1);
  localparam int KW       = $clog2(KERNEL);
  localparam int OCW      = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;

  localparam logic [RW-1:0]  R_LAST     = RW'(ROWS - 1);
  localparam logic [RW-1:0]  R_END      = RW'(OUT_ROWS * KERNEL);
  localparam logic [RW-1:0]  R_OUT_LAST = RW'(OUT_ROWS * KERNEL - 1);
  localparam logic [CW-1:0]  C_LAST     = CW'(COLS - 1);
  localparam logic [CW-1:0]  C_END      = CW'(OUT_COLS * KERNEL);
  localparam logic [CW-1:0]  C_OUT_LAST = CW'(OUT_COLS * KERNEL - 1);
  localparam logic [KW-1:0]  K_LAST     = KW'(KERNEL - 1);
  localparam logic [OCW-1:0] OC_LAST    = OCW'(OUT_COLS - 1);

  if (KERNEL < 2 || KERNEL > 8) begin : g_bad_kernel
    $error("stream_pool2d: KERNEL must be in 2..8");
  end
  if (MODE == 1 && (1 << LK) != KERNEL) begin : g_bad_avg
    $error("stream_pool2d: average mode needs a power-of-two KERNEL");
  end
  if (ROWS < KERNEL || COLS < KERNEL) begin : g_bad_frame
    $error("stream_pool2d: frame smaller than one window");
  end

  logic [RW-1:0]  r;
  logic [CW-1:0]  c;
  logic [KW-1:0]  kr;
  logic [KW-1:0]  kc;
  logic [OCW-1:0] oc;

  logic signed [ACC_W-1:0] hacc    [IN_CH];
  logic signed [ACC_W-1:0] row_mem [OUT_COLS][IN_CH];
  logic signed [ACC_W-1:0] smp     [IN_CH];
  logic signed [ACC_W-1:0] hnew    [IN_CH];
  logic signed [ACC_W-1:0] merged  [IN_CH];
  logic [DW-1:0]           res;

  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic          out_last_q;

  logic accept;
  logic in_region;
  logic emit;
  logic frame_end;
  logic last_win;

  // Max keeps the larger signed value; average keeps a running sum.
  function automatic logic signed [ACC_W-1:0] combine(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    if (MODE == 1) return a + b;
    else           return (a > b) ? a : b;
  endfunction

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign in_region = (r < R_END) && (c < C_END);
  assign emit      = accept && in_region && (kr == K_LAST) && (kc == K_LAST);
  assign frame_end = (r == R_LAST) && (c == C_LAST);
  assign last_win  = (r == R_OUT_LAST) && (c == C_OUT_LAST);

  // Per-channel horizontal and vertical merge of the current beat, and the
  // pooled pixel that results when this beat closes a window.
  always_comb begin
    smp    = '{default: '0};
    hnew   = '{default: '0};
    merged = '{default: '0};
    res    = '0;
    for (int ch = 0; ch < IN_CH; ch++) begin
      smp[ch]    = {{(2 * LK){bus.in_data[ch * DATA_W + DATA_W - 1]}},
                    bus.in_data[ch * DATA_W +: DATA_W]};
      hnew[ch]   = (kc == '0) ? smp[ch] : combine(hacc[ch], smp[ch]);
      merged[ch] = (kr == '0) ? hnew[ch] : combine(row_mem[oc][ch], hnew[ch]);
      if (MODE == 1) res[ch * DATA_W +: DATA_W] = DATA_W'(merged[ch] >>> (2 * LK));
      else           res[ch * DATA_W +: DATA_W] = DATA_W'(merged[ch]);
    end
  end

  // Raster position counters; window offsets and output column kept as
  // separate counters so no division is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r          <= '0;
      c          <= '0;
      kr         <= '0;
      kc         <= '0;
      oc         <= '0;
      frame_busy <= 1'b0;
    end else if (accept) begin
      frame_busy <= !frame_end;
      if (c == C_LAST) begin
        c  <= '0;
        kc <= '0;
        oc <= '0;
        if (r == R_LAST) begin
          r  <= '0;
          kr <= '0;
        end else begin
          r  <= r + RW'(1);
          kr <= (kr == K_LAST) ? '0 : kr + KW'(1);
        end
      end else begin
        c  <= c + CW'(1);
        kc <= (kc == K_LAST) ? '0 : kc + KW'(1);
        if (kc == K_LAST && oc != OC_LAST) oc <= oc + OCW'(1);
      end
    end
  end

  // Partial storage; beats outside the pooled region leave it untouched.
  always_ff @(posedge clk) begin
    if (accept && in_region) begin
      for (int ch = 0; ch < IN_CH; ch++) begin
        if (kc != K_LAST) hacc[ch] <= hnew[ch];
        else              row_mem[oc][ch] <= merged[ch];
      end
    end
  end

  // Output register: load on a closing beat, retire on out_ready; both may
  // happen in one cycle since in_ready already accounts for out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      out_data_q  <= res;
      out_last_q  <= last_win;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_pool2d.sv
// Directed bench for stream_pool2d: max pooling on a 4x4 frame, signed
// average pooling with two channels, a 5x5 frame with discarded edges,
// randomised back-pressure over back-to-back frames, and reset mid-frame.
module tb_stream_pool2d;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_pool2d_if #(.W(8))  bus_a ();
  stream_pool2d_if #(.W(16)) bus_b ();
  stream_pool2d_if #(.W(8))  bus_c ();
  logic fb_a, fb_b, fb_c;

  stream_pool2d #(.IN_CH(1), .DATA_W(8), .KERNEL(2), .ROWS(4), .COLS(4), .MODE(0))
    u_a (.clk(clk), .rst(rst), .bus(bus_a), .frame_busy(fb_a));
  stream_pool2d #(.IN_CH(2), .DATA_W(8), .KERNEL(2), .ROWS(2), .COLS(4), .MODE(1))
    u_b (.clk(clk), .rst(rst), .bus(bus_b), .frame_busy(fb_b));
  stream_pool2d #(.IN_CH(1), .DATA_W(8), .KERNEL(2), .ROWS(5), .COLS(5), .MODE(0))
    u_c (.clk(clk), .rst(rst), .bus(bus_c), .frame_busy(fb_c));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One beat into DUT A; called at a falling edge, returns at the next one
  // with the outputs that result from this beat.
  task automatic send_a(input logic [7:0] v, input logic ev, input logic [7:0] ed,
                        input logic el, input string tag);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = v;
    @(posedge clk);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    check({tag, " out_valid"}, bus_a.out_valid, ev);
    if (ev) begin
      check({tag, " out_data"}, bus_a.out_data, ed);
      check({tag, " out_last"}, bus_a.out_last, el);
    end
  endtask

  task automatic send_b(input logic [15:0] v, input logic ev, input logic [15:0] ed,
                        input logic el, input string tag);
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = v;
    @(posedge clk);
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    check({tag, " out_valid"}, bus_b.out_valid, ev);
    if (ev) begin
      check({tag, " out_data"}, bus_b.out_data, ed);
      check({tag, " out_last"}, bus_b.out_last, el);
    end
  endtask

  task automatic send_c(input logic [7:0] v, input logic ev, input logic [7:0] ed,
                        input logic el, input string tag);
    bus_c.in_valid = 1'b1;
    bus_c.in_data  = v;
    @(posedge clk);
    @(negedge clk);
    bus_c.in_valid = 1'b0;
    check({tag, " out_valid"}, bus_c.out_valid, ev);
    if (ev) begin
      check({tag, " out_data"}, bus_c.out_data, ed);
      check({tag, " out_last"}, bus_c.out_last, el);
    end
  endtask

  // Full 4x4 ramp frame base..base+15 into DUT A with four expected maxima.
  task automatic frame_a(input int base, input int e0, input int e1, input int e2,
                         input int e3, input string tag);
    int exp_w [4];
    exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2; exp_w[3] = e3;
    for (int i = 0; i < 16; i++) begin
      int r, c, w;
      logic ev;
      r  = i / 4;
      c  = i % 4;
      w  = (r / 2) * 2 + c / 2;
      ev = (r % 2 == 1) && (c % 2 == 1);
      send_a(8'(base + i), ev, 8'(exp_w[w]), (i == 15), $sformatf("%s px%0d", tag, i));
      if (i == 0)  check({tag, " busy_first"}, fb_a, 1);
      if (i == 15) check({tag, " busy_end"}, fb_a, 0);
    end
  endtask

  logic [15:0] vb   [16];
  logic [15:0] exp_b[4];
  logic [7:0]  pix  [48];
  logic [7:0]  exp_q[$];
  logic        expl_q[$];
  logic signed [7:0] m, sv;
  logic [7:0]  ed_r, held_d;
  logic        el_r, held, held_l;
  int idx, cyc, n_out, n_last;

  initial begin
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b1;
    bus_c.in_valid = 1'b0; bus_c.in_data = '0; bus_c.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    check("rst in_ready",  bus_a.in_ready, 1);
    check("rst out_valid", bus_a.out_valid, 0);
    check("rst out_data",  bus_a.out_data, 0);
    check("rst out_last",  bus_a.out_last, 0);
    check("rst busy",      fb_a, 0);
    check("rst b out_data", bus_b.out_data, 0);
    check("rst c out_valid", bus_c.out_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    // Max pooling on ramps; second frame negative to rule out a zero floor.
    frame_a(0, 5, 7, 13, 15, "max_ramp");
    frame_a(-100, -95, -93, -87, -85, "max_neg");
    repeat (3) @(negedge clk);
    check("idle out_valid", bus_a.out_valid, 0);

    // Average pooling, two channels, two windows per frame, two frames.
    vb[0]  = 16'hFF01; vb[1]  = 16'hFE02; vb[2]  = 16'h807F; vb[3]  = 16'h807F;
    vb[4]  = 16'hFE03; vb[5]  = 16'hFE04; vb[6]  = 16'h807F; vb[7]  = 16'h807E;
    vb[8]  = 16'h03FF; vb[9]  = 16'h0000; vb[10] = 16'h05F8; vb[11] = 16'h05F8;
    vb[12] = 16'h0000; vb[13] = 16'h0000; vb[14] = 16'h05F8; vb[15] = 16'h05F7;
    exp_b[0] = 16'hFE02; exp_b[1] = 16'h807E; exp_b[2] = 16'h00FF; exp_b[3] = 16'h05F7;
    for (int i = 0; i < 16; i++) begin
      int j;
      j = i % 8;
      send_b(vb[i], (j == 5 || j == 7), exp_b[(i / 8) * 2 + ((j == 7) ? 1 : 0)],
             (j == 7), $sformatf("avg px%0d", i));
    end

    // 5x5 frame: last row and column are consumed but never pooled.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 25; i++) begin
        int r, c;
        r = i / 5;
        c = i % 5;
        send_c(8'(f * 100 + i), (r == 1 || r == 3) && (c == 1 || c == 3),
               8'(f * 100 + i), (i == 18), $sformatf("edge f%0d px%0d", f, i));
        if (i == 19) check($sformatf("edge f%0d busy_trail", f), fb_c, 1);
        if (i == 24) check($sformatf("edge f%0d busy_end", f), fb_c, 0);
      end
    end

    // Three back-to-back random frames under random back-pressure.
    for (int i = 0; i < 48; i++) pix[i] = 8'($urandom_range(0, 255));
    for (int f = 0; f < 3; f++)
      for (int wr = 0; wr < 2; wr++)
        for (int wc = 0; wc < 2; wc++) begin
          m = pix[f * 16 + (2 * wr) * 4 + 2 * wc];
          for (int d = 1; d < 4; d++) begin
            sv = pix[f * 16 + (2 * wr + d / 2) * 4 + 2 * wc + d % 2];
            if (sv > m) m = sv;
          end
          exp_q.push_back(m);
          expl_q.push_back(wr == 1 && wc == 1);
        end
    idx = 0; cyc = 0; n_out = 0; n_last = 0; held = 1'b0; held_d = '0; held_l = 1'b0;
    while ((idx < 48 || n_out < 12) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        check("stall out_valid", bus_a.out_valid, 1);
        check("stall out_data",  bus_a.out_data, held_d);
        check("stall out_last",  bus_a.out_last, held_l);
      end
      bus_a.out_ready = 1'($urandom_range(0, 1));
      bus_a.in_valid  = (idx < 48);
      bus_a.in_data   = (idx < 48) ? pix[idx] : 8'h00;
      #1;
      if (bus_a.out_valid && bus_a.out_ready) begin
        n_out++;
        if (bus_a.out_last) n_last++;
        if (exp_q.size() > 0) begin
          ed_r = exp_q.pop_front();
          el_r = expl_q.pop_front();
          check($sformatf("rand out%0d data", n_out), bus_a.out_data, ed_r);
          check($sformatf("rand out%0d last", n_out), bus_a.out_last, el_r);
        end
      end
      held   = bus_a.out_valid && !bus_a.out_ready;
      held_d = bus_a.out_data;
      held_l = bus_a.out_last;
      if (bus_a.in_valid && bus_a.in_ready) idx++;
    end
    check("rand no_timeout", (cyc < 2000), 1);
    check("rand beats_in", idx, 48);
    check("rand outputs", n_out, 12);
    check("rand lasts", n_last, 3);
    @(negedge clk);
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rand drained", bus_a.out_valid, 0);

    // Reset after six beats with a pooled pixel pending, then a clean frame.
    for (int i = 0; i < 6; i++)
      send_a(8'(i), (i == 5), 8'd5, 1'b0, $sformatf("pre_rst px%0d", i));
    bus_a.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst out_valid", bus_a.out_valid, 0);
    check("mid_rst busy", fb_a, 0);
    check("mid_rst in_ready", bus_a.in_ready, 1);
    bus_a.out_ready = 1'b1;
    frame_a(16, 21, 23, 29, 31, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
